// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - time-multiplexed 5x7 LED matrix column driver with per-frame image latch
module matrix_column_scanner #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] column_4,
  input  logic [6:0] column_3,
  input  logic [6:0] column_2,
  input  logic [6:0] column_1,
  input  logic [6:0] column_0,
  output logic [6:0] rows,
  output logic [4:0] col_sel,
  output logic       frame_start
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   BLANK_W   = CW'(BLANK_CYCLES);
  localparam logic [2:0]      IDX_FIRST = 3'd4;
  localparam logic [6:0]      ROWS_OFF  = 7'h7F;

  // Parameter sanity: a slot needs at least two cycles and must leave room after blanking.
  if (CLK_DIV < 2) begin : g_bad_div
    $error("matrix_column_scanner: CLK_DIV must be at least 2");
  end
  if (BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank
    $error("matrix_column_scanner: BLANK_CYCLES must be less than CLK_DIV");
  end

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    frame_q [5];
  logic [6:0]    frame_d [5];
  logic [6:0]    rows_q, rows_d;
  logic [4:0]    col_sel_q, col_sel_d;
  logic          frame_start_q, frame_start_d;

  logic [6:0]    col_in [5];
  logic          latch;

  assign col_in[4] = column_4;
  assign col_in[3] = column_3;
  assign col_in[2] = column_2;
  assign col_in[1] = column_1;
  assign col_in[0] = column_0;

  // The whole image is captured only at the very first cycle of a frame so a picture never tears.
  assign latch = enable && (slot_cnt_q == '0) && (idx_q == IDX_FIRST);

  // Slot counter and column index; disabling parks the scan at the start of a fresh frame.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    idx_d      = idx_q;
    if (!enable) begin
      slot_cnt_d = '0;
      idx_d      = IDX_FIRST;
    end else if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == 3'd0) ? IDX_FIRST : idx_q - 3'd1;
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end
  end

  // Frame buffer: hold the image between latch cycles.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      frame_d[k] = latch ? col_in[k] : frame_q[k];
    end
  end

  // Output decode from the current counter state; registered so it lags the counters by one cycle.
  always_comb begin
    rows_d        = ROWS_OFF;
    col_sel_d     = 5'b00000;
    frame_start_d = latch;
    if (enable && (slot_cnt_q >= BLANK_W)) begin
      col_sel_d = 5'b00001 << idx_q;
      rows_d    = frame_q[idx_q];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_cnt_q    <= '0;
      idx_q         <= IDX_FIRST;
      rows_q        <= ROWS_OFF;
      col_sel_q     <= 5'b00000;
      frame_start_q <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        frame_q[k] <= ROWS_OFF;
      end
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      rows_q        <= rows_d;
      col_sel_q     <= col_sel_d;
      frame_start_q <= frame_start_d;
      for (int k = 0; k < 5; k++) begin
        frame_q[k] <= frame_d[k];
      end
    end
  end

  assign rows        = rows_q;
  assign col_sel     = col_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb/tb_matrix_column_scanner.sv - scoreboard bench for matrix_column_scanner
module tb_matrix_column_scanner;

  localparam int CD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 5 * CD;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [6:0] column_4, column_3, column_2, column_1, column_0;
  logic [6:0] rows;
  logic [4:0] col_sel;
  logic       frame_start;

  matrix_column_scanner #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .column_4    (column_4),
    .column_3    (column_3),
    .column_2    (column_2),
    .column_1    (column_1),
    .column_0    (column_0),
    .rows        (rows),
    .col_sel     (col_sel),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0] rows;
    logic [4:0] col_sel;
    logic       fs;
    logic       run;
  } exp_t;

  exp_t       expq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [6:0] img [5];
  int         t        = 0;
  int         cyc      = 0;
  int         last_fs  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [6:0] col_in(input int k);
    case (k)
      4:       return column_4;
      3:       return column_3;
      2:       return column_2;
      1:       return column_1;
      default: return column_0;
    endcase
  endfunction

  // Reference: time since the scan (re)started determines slot, column and blanking directly.
  task automatic model_step();
    exp_t e;
    int   pos, col, w;
    e.rows    = 7'h7F;
    e.col_sel = 5'b00000;
    e.fs      = 1'b0;
    e.run     = 1'b0;
    if (!reset_n) begin
      t = 0;
      for (int k = 0; k < 5; k++) img[k] = 7'h7F;
    end else if (!enable) begin
      t = 0;
    end else begin
      pos = t % FRAME;
      if (pos == 0) for (int k = 0; k < 5; k++) img[k] = col_in(k);
      col = 4 - pos / CD;
      w   = pos % CD;
      e.fs  = (pos == 0);
      e.run = 1'b1;
      if (w >= BL) begin
        e.col_sel = 5'(1 << col);
        e.rows    = img[col];
      end
      t++;
    end
    expq.push_back(e);
  endtask

  // Monitor: pops one expectation per clock and compares, plus structural invariants.
  always @(negedge clock) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rows", 32'(rows), 32'(e.rows));
      chk("col_sel", 32'(col_sel), 32'(e.col_sel));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("col_sel_onehot0", 32'($countones(col_sel) <= 1), 32'(1));
      if (!e.run) last_fs = -1;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
        last_fs = cyc;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    column_4 = 7'b1100011;
    column_3 = 7'b1001101;
    column_2 = 7'b1010101;
    column_1 = 7'b1011001;
    column_0 = 7'b1100011;
    run(2);

    reset_n = 1'b1;
    enable  = 1'b1;
    run(12);
    column_3 = 7'h00;
    run(68);

    run(18);
    enable   = 1'b0;
    column_4 = 7'($urandom);
    column_2 = 7'($urandom);
    run(3);
    enable = 1'b1;
    run(27);

    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    run(10 * FRAME);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(4))
          0: column_0 = 7'($urandom);
          1: column_1 = 7'($urandom);
          2: column_2 = 7'($urandom);
          3: column_3 = 7'($urandom);
          default: column_4 = 7'($urandom);
        endcase
      end
      enable  = ($urandom_range(99) != 0);
      reset_n = ($urandom_range(299) != 0);
      step();
    end
    enable  = 1'b1;
    reset_n = 1'b1;
    run(2 * FRAME);

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 32'(expq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
